// File: rtl/audio_pkg.sv
// Shared audio types and I2S frame geometry, also used by the sound generator output.
package audio_pkg;
  localparam int SAMPLE_W    = 24;
  localparam int SLOT_W      = 32;
  localparam int FRAME_BCLKS = 2 * SLOT_W;
  localparam int BIT_CNT_W   = $clog2(FRAME_BCLKS);
  localparam int IDX_W       = $clog2(SAMPLE_W);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [BIT_CNT_W-1:0]       bit_cnt_t;
  typedef logic [BIT_CNT_W-2:0]       slot_pos_t;

  // Serial bit for slot position p: MSB at p=1, zero padding at p=0 and beyond the sample.
  function automatic logic slot_bit(sample_t s, slot_pos_t p);
    int pos;
    logic [IDX_W-1:0] idx;
    pos      = int'(p);
    idx      = '0;
    slot_bit = 1'b0;
    if (pos >= 1 && pos <= SAMPLE_W) begin
      idx      = IDX_W'(SAMPLE_W - pos);
      slot_bit = s[idx];
    end
  endfunction
endpackage

// File: rtl/audio_dac_serializer_if.sv
// Pull-style sample handshake between the sound generator and the DAC serializer.
interface audio_dac_serializer_if;
  import audio_pkg::*;

  sample_t sample_in;
  logic    sample_valid;
  logic    sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/bclk_gen.sv
// Bit-clock divider: registered BCLK plus single-cycle strobes ahead of each edge.
module bclk_gen #(
  parameter int HALF = 8
) (
  input  logic clk,
  input  logic resetn,
  output logic bclk,
  output logic fall_evt,
  output logic rise_evt
);
  localparam int CNT_W = $clog2(HALF);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             last;

  always_comb begin
    last      = (div_cnt_q == LAST);
    div_cnt_d = last ? '0 : div_cnt_q + 1'b1;
    bclk_d    = last ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk     = bclk_q;
  assign fall_evt = last & bclk_q;
  assign rise_evt = last & ~bclk_q;
endmodule

// File: rtl/audio_dac_serializer.sv
// Mono-to-I2S serializer: pulls one sample per 64-BCLK frame and sends it in both slots.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  audio_dac_serializer_if.slave  smp_if,
  output logic                   underrun,
  input  logic                   underrun_clr,
  output logic                   aud_bclk,
  output logic                   aud_daclrck,
  output logic                   aud_dacdat
);
  logic     fall_evt;
  logic     bclk_rise_unused;
  logic     frame_start;
  bit_cnt_t bit_cnt_q, bit_cnt_d;
  sample_t  hold_q, hold_d;
  logic     lrck_q, lrck_d;
  logic     dat_q, dat_d;
  logic     underrun_q, underrun_d;

  // Rising strobe is left for a future capture path.
  bclk_gen #(.HALF(BCLK_HALF)) u_bclk_gen (
    .clk      (clk),
    .resetn   (resetn),
    .bclk     (aud_bclk),
    .fall_evt (fall_evt),
    .rise_evt (bclk_rise_unused)
  );

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    dat_d      = dat_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;
    // Gated by resetn so no pull strobe escapes while the line is being reset.
    frame_start = resetn && fall_evt && (bit_cnt_q == bit_cnt_t'(FRAME_BCLKS - 1));

    if (fall_evt) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      lrck_d    = bit_cnt_d[BIT_CNT_W-1];
      dat_d     = slot_bit(hold_q, bit_cnt_d[BIT_CNT_W-2:0]);
    end

    if (frame_start && smp_if.sample_valid) begin
      hold_d = smp_if.sample_in;
    end

    if (frame_start && !smp_if.sample_valid) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bit_cnt_q  <= '1;
      hold_q     <= '0;
      lrck_q     <= 1'b0;
      dat_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      underrun_q <= underrun_d;
    end
  end

  assign smp_if.sample_ready = frame_start;
  assign underrun            = underrun_q;
  assign aud_daclrck         = lrck_q;
  assign aud_dacdat          = dat_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: two instances (BCLK_HALF=8 and 2), frame table plus per-cycle reference.
module tb_audio_dac_serializer;
  import audio_pkg::*;

  typedef struct {
    sample_t smp;
    bit      valid;
    bit      stray;
    int      clr_mode;   // 0 none, 1 pulse mid-frame, 2 pulse in the ready cycle
    sample_t exp_word;
    bit      exp_und;
  } vec_t;

  logic       clk = 1'b0;
  logic [1:0] rstn = 2'b00;
  logic [1:0] vld  = 2'b00;
  logic [1:0] clr  = 2'b00;
  logic [1:0] rdy, bclk, lrck, dat, und;
  sample_t    smp [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g
    audio_dac_serializer_if ifc ();
    assign ifc.sample_in    = smp[gi];
    assign ifc.sample_valid = vld[gi];
    assign rdy[gi]          = ifc.sample_ready;

    audio_dac_serializer #(.BCLK_HALF(gi == 0 ? 8 : 2)) dut (
      .clk          (clk),
      .resetn       (rstn[gi]),
      .smp_if       (ifc),
      .underrun     (und[gi]),
      .underrun_clr (clr[gi]),
      .aud_bclk     (bclk[gi]),
      .aud_daclrck  (lrck[gi]),
      .aud_dacdat   (dat[gi])
    );
  end

  function automatic int hh(int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic bit ready_at(int d, int tt);
    int h = hh(d);
    return (tt >= 2*h - 1) && (((tt - (2*h - 1)) % (128*h)) == 0);
  endfunction

  task automatic check(string name, int d, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, got, exp);
    end
  endtask

  // Reference model: cycle index since reset release, captured sample and underrun flag.
  int      t  [2];
  bit      seen [2];
  sample_t fs [2];
  bit      um [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn[d]) begin
        t[d] = 0; fs[d] = '0; um[d] = 1'b0; seen[d] = 1'b1;
      end else if (seen[d]) begin
        int h, k, p, tt;
        logic e_lr, e_dat, e_rdy;
        h = hh(d); tt = t[d];
        e_lr = 1'b0; e_dat = 1'b0;
        if (tt >= 2*h) begin
          k = ((tt - 2*h) / (2*h)) % 64;
          p = k % 32;
          e_lr = (k >= 32);
          if (p >= 1 && p <= SAMPLE_W) e_dat = fs[d][SAMPLE_W - p];
        end
        e_rdy = ready_at(d, tt);
        check("pins{bclk,lrck,dat,rdy,und}", d,
              32'({bclk[d], lrck[d], dat[d], rdy[d], und[d]}),
              32'({1'(((tt / h) % 2)), e_lr, e_dat, e_rdy, um[d]}));
        if (e_rdy && vld[d]) fs[d] = smp[d];
        if (e_rdy && !vld[d]) um[d] = 1'b1;
        else if (clr[d]) um[d] = 1'b0;
        t[d] = tt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int d, int ncyc);
    rstn[d] = 1'b0;
    repeat (ncyc) tick();
    rstn[d] = 1'b1;
  endtask

  task automatic wait_ready(int d);
    int n = 0;
    while (!ready_at(d, t[d]) && n < 140*hh(d)) begin
      tick();
      n++;
    end
    if (!ready_at(d, t[d])) check("ready_timeout", d, 32'd0, 32'd1);
  endtask

  task automatic ready_latency(int d, int exp);
    int n = 0;
    while (!rdy[d] && n < 200) begin
      tick();
      n++;
    end
    check("ready_latency", d, 32'(n), 32'(exp));
  endtask

  // Drive one frame from its ready cycle and deserialize both slots from the pins.
  task automatic run_frame(int d, vec_t r);
    int h, k, p;
    sample_t lw, rw;
    bit pad_bad, lr_bad;
    h = hh(d); lw = '0; rw = '0; pad_bad = 0; lr_bad = 0;
    wait_ready(d);
    for (int i = 0; i < 128*h; i++) begin
      vld[d] = 1'b0;
      smp[d] = sample_t'($urandom);
      if (i == 0) begin
        vld[d] = r.valid;
        if (r.valid) smp[d] = r.smp;
      end else if (r.stray && (i == 1 || i == 64*h)) begin
        vld[d] = 1'b1;
        smp[d] = 24'h123456;
      end
      clr[d] = (r.clr_mode == 2 && i == 0) || (r.clr_mode == 1 && i == 5*h);
      if (i >= h + 1 && ((i - 1 - h) % (2*h)) == 0) begin
        k = (i - 1 - h) / (2*h);
        p = k % 32;
        if (lrck[d] !== (k >= 32)) lr_bad = 1;
        if (p >= 1 && p <= SAMPLE_W) begin
          if (k < 32) lw[SAMPLE_W - p] = dat[d];
          else        rw[SAMPLE_W - p] = dat[d];
        end else if (dat[d] !== 1'b0) begin
          pad_bad = 1;
        end
      end
      if (i == 128*h - 1) check("underrun_end", d, 32'(und[d]), 32'(r.exp_und));
      tick();
    end
    vld[d] = 1'b0;
    clr[d] = 1'b0;
    check("left_word", d, 32'(lw), 32'(r.exp_word));
    check("right_word", d, 32'(rw), 32'(r.exp_word));
    check("pad_zero", d, 32'(pad_bad), 32'd0);
    check("lrck_slot", d, 32'(lr_bad), 32'd0);
    $display("frame dut%0d: valid=%0b smp=%h left=%h right=%h und=%0b", d, r.valid, r.smp, lw, rw, und[d]);
  endtask

  function automatic vec_t mk(sample_t s, bit v, bit st, int cm, sample_t ew, bit eu);
    vec_t r;
    r.smp = s; r.valid = v; r.stray = st; r.clr_mode = cm; r.exp_word = ew; r.exp_und = eu;
    return r;
  endfunction

  vec_t tab0 [10];
  vec_t tab1 [6];

  initial begin
    sample_t last;
    bit      lund;
    bit      v;
    sample_t s;

    tab0[0] = mk(24'hA5A5A5, 1, 0, 0, 24'hA5A5A5, 0);
    tab0[1] = mk(24'h800001, 1, 0, 0, 24'h800001, 0);
    tab0[2] = mk(24'h000000, 0, 0, 0, 24'h800001, 1);
    tab0[3] = mk(24'h13579B, 1, 0, 1, 24'h13579B, 0);
    tab0[4] = mk(24'h000000, 0, 0, 2, 24'h13579B, 1);
    tab0[5] = mk(24'h000000, 0, 1, 0, 24'h13579B, 1);
    tab0[6] = mk(24'h000000, 0, 0, 1, 24'h13579B, 0);
    last = 24'h13579B; lund = 0;
    for (int i = 7; i < 10; i++) begin
      v = 1'($urandom % 2); s = sample_t'($urandom);
      if (v) last = s; else lund = 1;
      tab0[i] = mk(s, v, 0, 0, last, lund);
    end
    tab1[0] = mk(24'hFFFFFF, 1, 0, 0, 24'hFFFFFF, 0);
    last = 24'hFFFFFF; lund = 0;
    for (int i = 1; i < 6; i++) begin
      v = 1'($urandom % 2); s = sample_t'($urandom);
      if (v) last = s; else lund = 1;
      tab1[i] = mk(s, v, 0, 0, last, lund);
    end

    smp[0] = '0; smp[1] = '0;
    rstn = 2'b00;
    tick(); tick();
    rstn = 2'b11;
    check("post_reset_pins", 0, 32'({bclk[0], lrck[0], dat[0], rdy[0], und[0]}), 32'd0);
    ready_latency(0, 15);

    for (int i = 0; i < 10; i++) run_frame(0, tab0[i]);

    // One-cycle reset in the middle of the right slot (bit 40).
    wait_ready(0);
    repeat (1 + 40*16 + 3) tick();
    do_reset(0, 1);
    check("mid_reset_pins", 0, 32'({bclk[0], lrck[0], dat[0], rdy[0], und[0]}), 32'd0);
    ready_latency(0, 15);
    run_frame(0, mk(24'h5A5A5A, 1, 0, 0, 24'h5A5A5A, 0));

    do_reset(1, 2);
    check("post_reset_pins", 1, 32'({bclk[1], lrck[1], dat[1], rdy[1], und[1]}), 32'd0);
    ready_latency(1, 3);
    for (int i = 0; i < 6; i++) run_frame(1, tab1[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    n_bad++;
    $display("FAIL watchdog: got no completion expected completion before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
